// File: rtl/k_and_s_pkg.sv
// Shared K&S types used by the RAM arbiter.
//   arb_state_t : arbiter FSM states
//   arb_owner_t : which requester owns (or last owned) the RAM port
package k_and_s_pkg;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_RD_WAIT = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_EXT = 1'b1
    } arb_owner_t;

    localparam int ARB_LAT_W = 2;

endpackage

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of the shared K&S data/instruction RAM.
// The CPU datapath and the external load/debug port compete for one
// access per cycle; ties are resolved round-robin, and the external port
// may hold ext_lock to keep the bus for a burst. Reads are tracked so each
// requester gets exactly one rvalid pulse, RD_LAT cycles after its grant.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   cpu_req/we/addr/wdata           CPU request and command
//   ext_req/we/addr/wdata, ext_lock external request, command and burst lock
//   cpu_gnt, ext_gnt                access issued to RAM this cycle
//   cpu_rvalid/rdata, ext_rvalid/rdata  read return, rdata is 0 unless rvalid
//   ram_addr, ram_we, ram_wdata     RAM command
//   ram_rdata                       RAM read data, RD_LAT cycles after command
//   busy                            read outstanding, no grant this cycle
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ARB_IDLE    | no read outstanding; grants allowed
// ARB_RD_WAIT | read outstanding; lat_cnt counts down, respond when it hits 0
module ram_arbiter
    import k_and_s_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    input  logic              ext_lock,
    output logic              cpu_gnt,
    output logic              ext_gnt,
    output logic              cpu_rvalid,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [DATA_W-1:0] ext_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    // With RD_LAT = 1 this loads 0, so the cycle after the grant responds.
    localparam logic [ARB_LAT_W-1:0] LAT_LOAD = ARB_LAT_W'(RD_LAT - 1);

    arb_state_t             state, state_nxt;
    arb_owner_t             last_owner, last_owner_nxt;
    arb_owner_t             rd_owner, rd_owner_nxt;
    arb_owner_t             winner;
    logic [ARB_LAT_W-1:0]   lat_cnt, lat_cnt_nxt;
    logic                   respond;

    // Round-robin pick: a single requester always wins; on a tie the one not
    // granted last wins, except that a locked EXT that owned the bus keeps it.
    function automatic arb_owner_t rr_pick(input logic       c_req,
                                           input logic       e_req,
                                           input logic       lock,
                                           input arb_owner_t last);
        arb_owner_t pick;
        pick = OWN_CPU;
        if (c_req && e_req) begin
            if (last == OWN_EXT && lock) pick = OWN_EXT;
            else if (last == OWN_EXT)    pick = OWN_CPU;
            else                         pick = OWN_EXT;
        end else if (e_req) begin
            pick = OWN_EXT;
        end
        return pick;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            last_owner <= OWN_EXT;
            rd_owner   <= OWN_CPU;
            lat_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            rd_owner   <= rd_owner_nxt;
            lat_cnt    <= lat_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        rd_owner_nxt   = rd_owner;
        lat_cnt_nxt    = lat_cnt;
        winner         = OWN_CPU;
        cpu_gnt        = 1'b0;
        ext_gnt        = 1'b0;
        ram_we         = 1'b0;
        ram_addr       = cpu_addr;
        ram_wdata      = cpu_wdata;

        respond = (state == ARB_RD_WAIT) && (lat_cnt == '0);
        busy    = (state == ARB_RD_WAIT) && (lat_cnt != '0);

        // lat_cnt only decrements while non-zero: the zero cycle either
        // exits to idle or is overridden below by a reload.
        if (state == ARB_RD_WAIT) begin
            if (respond) state_nxt   = ARB_IDLE;
            else         lat_cnt_nxt = lat_cnt - 1'b1;
        end

        // Grants are gated by rst_n so nothing reaches the RAM during reset.
        if (rst_n && !busy && (cpu_req || ext_req)) begin
            winner = rr_pick(cpu_req, ext_req, ext_lock, last_owner);
            if (winner == OWN_EXT) begin
                ext_gnt   = 1'b1;
                ram_we    = ext_we;
                ram_addr  = ext_addr;
                ram_wdata = ext_wdata;
            end else begin
                cpu_gnt   = 1'b1;
                ram_we    = cpu_we;
            end
            last_owner_nxt = winner;
            if (!ram_we) begin
                state_nxt    = ARB_RD_WAIT;
                lat_cnt_nxt  = LAT_LOAD;
                rd_owner_nxt = winner;
            end
        end
    end

    assign cpu_rvalid = respond && (rd_owner == OWN_CPU);
    assign ext_rvalid = respond && (rd_owner == OWN_EXT);
    assign cpu_rdata  = cpu_rvalid ? ram_rdata : '0;
    assign ext_rdata  = ext_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: three instances (RD_LAT = 1, 2, 3) share one
// stimulus stream, each with its own behavioural RAM. A reference model
// tracks outstanding reads by absolute due cycle and predicts every output.
module tb_ram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        mem_load;
    logic        cpu_req, cpu_we, ext_req, ext_we, ext_lock;
    logic [4:0]  cpu_addr, ext_addr;
    logic [15:0] cpu_wdata, ext_wdata;

    logic        cpu_gnt_w    [3];
    logic        ext_gnt_w    [3];
    logic        cpu_rvalid_w [3];
    logic        ext_rvalid_w [3];
    logic [15:0] cpu_rdata_w  [3];
    logic [15:0] ext_rdata_w  [3];
    logic [4:0]  ram_addr_w   [3];
    logic        ram_we_w     [3];
    logic [15:0] ram_wdata_w  [3];
    logic [15:0] ram_rdata_w  [3];
    logic        busy_w       [3];

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // reference model state, per instance
    bit          m_last [3];     // 1 = EXT granted last
    bit          m_pv   [3];     // read pending
    bit          m_pown [3];     // 1 = pending read belongs to EXT
    int          m_pdue [3];     // cycle in which rvalid is due
    logic [15:0] m_pdata[3];
    logic [15:0] m_mem  [3][32];

    function automatic logic [15:0] init_val(input int g, input int a);
        if (a == 3) return 16'h1234;
        return 16'(a * 291 + g * 1911 + 66);
    endfunction

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_lat
        logic [15:0] mem  [32];
        logic [15:0] pipe [3];

        ram_arbiter #(.ADDR_W(5), .DATA_W(16), .RD_LAT(g + 1)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .cpu_req    (cpu_req),
            .cpu_we     (cpu_we),
            .cpu_addr   (cpu_addr),
            .cpu_wdata  (cpu_wdata),
            .ext_req    (ext_req),
            .ext_we     (ext_we),
            .ext_addr   (ext_addr),
            .ext_wdata  (ext_wdata),
            .ext_lock   (ext_lock),
            .cpu_gnt    (cpu_gnt_w[g]),
            .ext_gnt    (ext_gnt_w[g]),
            .cpu_rvalid (cpu_rvalid_w[g]),
            .ext_rvalid (ext_rvalid_w[g]),
            .cpu_rdata  (cpu_rdata_w[g]),
            .ext_rdata  (ext_rdata_w[g]),
            .ram_addr   (ram_addr_w[g]),
            .ram_we     (ram_we_w[g]),
            .ram_wdata  (ram_wdata_w[g]),
            .ram_rdata  (ram_rdata_w[g]),
            .busy       (busy_w[g])
        );

        always @(posedge clk) begin
            if (mem_load) begin
                for (int a = 0; a < 32; a++) mem[a] <= init_val(g, a);
            end else if (ram_we_w[g]) begin
                mem[ram_addr_w[g]] <= ram_wdata_w[g];
            end
            pipe[0] <= mem[ram_addr_w[g]];
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end

        assign ram_rdata_w[g] = pipe[g];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Sample at the falling edge, compare against the model, then advance it.
    task automatic half_check();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bit          busy_e, resp, gnt_any, w_ext, we_e;
            logic [4:0]  a_e;
            logic [15:0] d_e;
            string       p;
            p       = $sformatf("L%0d_", i + 1);
            busy_e  = m_pv[i] && (m_pdue[i] > cyc);
            resp    = m_pv[i] && (m_pdue[i] == cyc);
            gnt_any = !busy_e && (cpu_req || ext_req);
            if (cpu_req && ext_req) w_ext = m_last[i] ? ext_lock : 1'b1;
            else                    w_ext = ext_req;
            we_e = gnt_any && (w_ext ? ext_we : cpu_we);
            a_e  = (gnt_any && w_ext) ? ext_addr  : cpu_addr;
            d_e  = (gnt_any && w_ext) ? ext_wdata : cpu_wdata;

            chk({p, "cpu_gnt"},    cpu_gnt_w[i],    gnt_any && !w_ext);
            chk({p, "ext_gnt"},    ext_gnt_w[i],    gnt_any && w_ext);
            chk({p, "busy"},       busy_w[i],       busy_e);
            chk({p, "cpu_rvalid"}, cpu_rvalid_w[i], resp && !m_pown[i]);
            chk({p, "ext_rvalid"}, ext_rvalid_w[i], resp && m_pown[i]);
            chk({p, "cpu_rdata"},  cpu_rdata_w[i],  (resp && !m_pown[i]) ? m_pdata[i] : 16'h0);
            chk({p, "ext_rdata"},  ext_rdata_w[i],  (resp && m_pown[i])  ? m_pdata[i] : 16'h0);
            chk({p, "ram_we"},     ram_we_w[i],     we_e);
            chk({p, "ram_addr"},   ram_addr_w[i],   a_e);
            chk({p, "ram_wdata"},  ram_wdata_w[i],  d_e);

            if (resp) m_pv[i] = 1'b0;
            if (gnt_any) begin
                m_last[i] = w_ext;
                if (we_e) begin
                    m_mem[i][a_e] = d_e;
                end else begin
                    m_pv[i]    = 1'b1;
                    m_pdue[i]  = cyc + i + 1;
                    m_pown[i]  = w_ext;
                    m_pdata[i] = m_mem[i][a_e];
                end
            end
        end
        cyc++;
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        half_check();
        next_edge();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                string p;
                p = $sformatf("rst_L%0d_", i + 1);
                chk({p, "cpu_gnt"},    cpu_gnt_w[i],    1'b0);
                chk({p, "ext_gnt"},    ext_gnt_w[i],    1'b0);
                chk({p, "cpu_rvalid"}, cpu_rvalid_w[i], 1'b0);
                chk({p, "ext_rvalid"}, ext_rvalid_w[i], 1'b0);
                chk({p, "busy"},       busy_w[i],       1'b0);
                chk({p, "ram_we"},     ram_we_w[i],     1'b0);
                chk({p, "cpu_rdata"},  cpu_rdata_w[i],  16'h0);
                chk({p, "ext_rdata"},  ext_rdata_w[i],  16'h0);
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_pv[i]   = 1'b0;
            m_last[i] = 1'b1;
        end
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [4:0] a, input logic [15:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_ext(input logic req, input logic we, input logic [4:0] a, input logic [15:0] d);
        ext_req = req; ext_we = we; ext_addr = a; ext_wdata = d;
    endtask

    initial begin
        clk      = 1'b0;
        rst_n    = 1'b0;
        mem_load = 1'b1;
        ext_lock = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_last[i] = 1'b1;
            m_pv[i]   = 1'b0;
            m_pown[i] = 1'b0;
            m_pdue[i] = 0;
            m_pdata[i] = '0;
            for (int a = 0; a < 32; a++) m_mem[i][a] = init_val(i, a);
        end

        // reset with both ports requesting, then the first tie goes to CPU
        set_cpu(1'b1, 1'b1, 5'h10, 16'hAAAA);
        set_ext(1'b1, 1'b1, 5'h11, 16'hBBBB);
        do_reset(3);
        mem_load = 1'b0;
        half_check();
        chk("first_tie_cpu", cpu_gnt_w[0], 1'b1);
        next_edge();

        // CPU read of RAM[3] on the RD_LAT = 2 instance
        set_cpu(1'b1, 1'b0, 5'h03, 16'h0);
        set_ext(1'b0, 1'b0, 5'h00, 16'h0);
        half_check();
        chk("rd2_gnt", cpu_gnt_w[1], 1'b1);
        next_edge();
        cpu_req = 1'b0;
        half_check();
        chk("rd2_busy", busy_w[1], 1'b1);
        next_edge();
        half_check();
        chk("rd2_rvalid", cpu_rvalid_w[1], 1'b1);
        chk("rd2_rdata",  cpu_rdata_w[1],  16'h1234);
        chk("rd2_ext_rvalid", ext_rvalid_w[1], 1'b0);
        next_edge();
        tick();

        // round-robin writes, kept in the upper half of the RAM
        for (int k = 0; k < 6; k++) begin
            set_cpu(1'b1, 1'b1, 5'(16 + $urandom_range(0, 15)), 16'($urandom));
            set_ext(1'b1, 1'b1, 5'(16 + $urandom_range(0, 15)), 16'($urandom));
            tick();
        end

        // lock held for 4 EXT writes, then released
        ext_lock = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ext_wdata = 16'($urandom);
            half_check();
            chk("lock4_ext", ext_gnt_w[0], 1'b1);
            next_edge();
        end
        ext_lock = 1'b0;
        half_check();
        chk("lock4_cpu", cpu_gnt_w[0], 1'b1);
        next_edge();

        // lock dropped after 2 writes
        ext_lock = 1'b1;
        tick();
        tick();
        ext_lock = 1'b0;
        half_check();
        chk("lock2_cpu", cpu_gnt_w[0], 1'b1);
        next_edge();

        // pipelined reads on the RD_LAT = 1 instance
        set_cpu(1'b1, 1'b0, 5'h01, 16'h0);
        set_ext(1'b0, 1'b0, 5'h00, 16'h0);
        tick();
        set_cpu(1'b0, 1'b0, 5'h00, 16'h0);
        set_ext(1'b1, 1'b0, 5'h02, 16'h0);
        half_check();
        chk("pipe_cpu_rvalid", cpu_rvalid_w[0], 1'b1);
        chk("pipe_cpu_rdata",  cpu_rdata_w[0],  init_val(0, 1));
        chk("pipe_ext_gnt",    ext_gnt_w[0],    1'b1);
        next_edge();
        ext_req = 1'b0;
        half_check();
        chk("pipe_ext_rvalid", ext_rvalid_w[0], 1'b1);
        chk("pipe_ext_rdata",  ext_rdata_w[0],  init_val(0, 2));
        next_edge();
        for (int k = 0; k < 3; k++) tick();

        // reset one cycle after a CPU read grant on the RD_LAT = 3 instance
        set_cpu(1'b1, 1'b0, 5'h04, 16'h0);
        tick();
        cpu_req = 1'b0;
        do_reset(1);
        set_ext(1'b1, 1'b0, 5'h05, 16'h0);
        half_check();
        chk("rstrd_ext_gnt",    ext_gnt_w[2],    1'b1);
        chk("rstrd_busy",       busy_w[2],       1'b0);
        chk("rstrd_cpu_rvalid", cpu_rvalid_w[2], 1'b0);
        next_edge();
        ext_req = 1'b0;
        for (int k = 0; k < 4; k++) tick();

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            set_cpu(1'($urandom_range(0, 9) < 6), 1'($urandom), 5'($urandom), 16'($urandom));
            set_ext(1'($urandom_range(0, 9) < 6), 1'($urandom), 5'($urandom), 16'($urandom));
            ext_lock = 1'($urandom_range(0, 3) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
